r5fp_idiv_arb: RTL and testbench
================================

R5FP_IDIV_ARB -- requirements
Module: r5fp_idiv_arb

Interface
REQ-001 Parameter: W, default 26, shared integer-divider operand/result width; SHALL be even.
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: p0_N, p0_D  in  W each  requester-0 dividend/divisor, sampled when p0_strobe=1.
REQ-005 Port: p0_strobe  in  1  requester-0 one-cycle request pulse.
REQ-006 Port: p0_ready  out  1  requester-0 may strobe this cycle.
REQ-007 Port: p0_Quo, p0_Rem  out  W each  requester-0 last quotient/remainder.
REQ-008 Port: p0_done  out  1  one-cycle pulse: p0_Quo/p0_Rem updated.
REQ-009 Ports p1_N, p1_D, p1_strobe, p1_ready, p1_Quo, p1_Rem, p1_done SHALL mirror REQ-004..008 for requester 1.
REQ-010 Port: idiv_N, idiv_D  out  W each  operands to shared divider.
REQ-011 Port: idiv_strobe  out  1  one-cycle divider start pulse.
REQ-012 Port: idiv_Quo, idiv_Rem  in  W each  divider results, valid only while idiv_done=1.
REQ-013 Port: idiv_done  in  1  divider one-cycle completion pulse.
REQ-014 Port: idiv_ready  in  1  divider idle and able to accept idiv_strobe.

Function
REQ-015 Each port SHALL own a 1-entry pending buffer (valid bit + N + D); pX_ready = ~pendX.
REQ-016 pX_strobe with pX_ready=1 SHALL load pendX with pX_N/pX_D at that edge; pX_strobe with pX_ready=0 SHALL be ignored with no state change.
REQ-017 FSM states: IDLE, ISSUE, WAIT.
REQ-018 IDLE: if idiv_ready=1 and any pend valid, SHALL register grant and go to ISSUE; otherwise stay.
REQ-019 Grant: only one pending -> that port; both pending -> port ~last, where last is the port most recently completed (reset value 1, so port 0 wins first tie).
REQ-020 ISSUE: idiv_strobe=1 for exactly this one cycle; next state WAIT.
REQ-021 idiv_N/idiv_D SHALL equal the granted pend buffer in ISSUE and WAIT, and 0 in IDLE.
REQ-022 WAIT: on idiv_done=1, SHALL latch idiv_Quo/idiv_Rem into the granted port's result registers, clear that pend valid, set last=grant, pulse that port's done the next cycle, go to IDLE.
REQ-023 idiv_done outside WAIT SHALL be ignored.
REQ-024 Result registers SHALL hold until the same port's next completion; the other port's results are never disturbed.
REQ-025 Latency: strobe at cycle t into an idle arbiter with idiv_ready=1 -> idiv_strobe at t+2; idiv_done at cycle u -> pX_done and pX_ready=1 at u+1.
REQ-026 A strobe on port X at cycle u+1 (ready just re-asserted) SHALL be accepted; the FSM is in IDLE at u+1 and may grant the other port's pending request in that same cycle.
REQ-027 At most one divider operation SHALL be outstanding; idiv_strobe SHALL never assert while state is WAIT.
REQ-028 Starvation bound: with both ports continuously requesting, grants SHALL strictly alternate.

Reset
REQ-029 reset=1 SHALL force state IDLE, pend0/pend1 valid=0, last=1, all done outputs 0, idiv_strobe=0, all result registers 0, p0_ready=p1_ready=1 on the following cycle.
REQ-030 reset during WAIT SHALL discard the in-flight result; a later idiv_done is ignored, and the next grant waits for idiv_ready=1.

Verification
REQ-031 Single request: p0 N=0x0C00000, D=0x0400000, divider model latency 13 -> idiv_strobe at t+2, p0_done at t+16, p0_Quo matches model, p1_done never pulses.
REQ-032 Simultaneous p0/p1 strobes after reset -> p0 served first, p1 issued in the cycle after p0_done; next tie goes to p0.
REQ-033 Back-to-back p0 strobes while pending -> second ignored; exactly one p0_done.
REQ-034 idiv_ready held 0 for 20 cycles with p1 pending -> no idiv_strobe until idiv_ready=1, then issue two cycles later.
REQ-035 Spurious idiv_done in IDLE -> no done pulse, result registers unchanged.
REQ-036 reset asserted mid-WAIT, late idiv_done returned -> both ports ready, no done pulse, results 0.

Source files
------------

// File: rtl/r5fp_idiv_arb.sv
// r5fp_idiv_arb: two-port arbiter that shares one iterative integer divider.
// Each requester owns a one-entry pending buffer. A small FSM grants the
// divider to one pending request at a time. When both ports are waiting,
// the grant goes to the port that was not served most recently.
module r5fp_idiv_arb #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    // requester 0
    input  logic [W-1:0] p0_N,
    input  logic [W-1:0] p0_D,
    input  logic         p0_strobe,
    output logic         p0_ready,
    output logic [W-1:0] p0_Quo,
    output logic [W-1:0] p0_Rem,
    output logic         p0_done,
    // requester 1
    input  logic [W-1:0] p1_N,
    input  logic [W-1:0] p1_D,
    input  logic         p1_strobe,
    output logic         p1_ready,
    output logic [W-1:0] p1_Quo,
    output logic [W-1:0] p1_Rem,
    output logic         p1_done,
    // shared divider
    output logic [W-1:0] idiv_N,
    output logic [W-1:0] idiv_D,
    output logic         idiv_strobe,
    input  logic [W-1:0] idiv_Quo,
    input  logic [W-1:0] idiv_Rem,
    input  logic         idiv_done,
    input  logic         idiv_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t       state;
    logic         grant;     // port that owns the divider in ISSUE/WAIT
    logic         last;      // port most recently completed
    logic         pend0;
    logic         pend1;
    logic [W-1:0] pend0_n;
    logic [W-1:0] pend0_d;
    logic [W-1:0] pend1_n;
    logic [W-1:0] pend1_d;
    logic         sel;

    assign p0_ready = ~pend0;
    assign p1_ready = ~pend1;

    // Port choice for the next grant: a lone request wins outright, a tie goes to the port not served last.
    always_comb begin
        sel = 1'b0;
        if (pend0 && pend1) begin
            sel = ~last;
        end else begin
            sel = pend1;
        end
    end

    // Operand capture for the pending buffers; the valid bits gate which strobes land here.
    always_ff @(posedge clk) begin
        if (p0_strobe && !pend0) begin
            pend0_n <= p0_N;
            pend0_d <= p0_D;
        end
        if (p1_strobe && !pend1) begin
            pend1_n <= p1_N;
            pend1_d <= p1_D;
        end
    end

    // Arbitration FSM with pending-valid bits, registered divider handshake and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
            idiv_strobe <= 1'b0;
            idiv_N      <= '0;
            idiv_D      <= '0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_Quo      <= '0;
            p0_Rem      <= '0;
            p1_Quo      <= '0;
            p1_Rem      <= '0;
        end else begin
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            idiv_strobe <= 1'b0;

            // A strobe can only land on an empty buffer, so it never collides with the clear below.
            if (p0_strobe && !pend0) begin
                pend0 <= 1'b1;
            end
            if (p1_strobe && !pend1) begin
                pend1 <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (idiv_ready && (pend0 || pend1)) begin
                        grant       <= sel;
                        idiv_N      <= sel ? pend1_n : pend0_n;
                        idiv_D      <= sel ? pend1_d : pend0_d;
                        idiv_strobe <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A completion seen here cannot belong to this operation, so it is dropped.
                    state <= WAIT;
                end
                WAIT: begin
                    if (idiv_done) begin
                        if (grant) begin
                            p1_Quo  <= idiv_Quo;
                            p1_Rem  <= idiv_Rem;
                            p1_done <= 1'b1;
                            pend1   <= 1'b0;
                        end else begin
                            p0_Quo  <= idiv_Quo;
                            p0_Rem  <= idiv_Rem;
                            p0_done <= 1'b1;
                            pend0   <= 1'b0;
                        end
                        last   <= grant;
                        idiv_N <= '0;
                        idiv_D <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r5fp_idiv_arb.sv
// tb_r5fp_idiv_arb: directed bench for the two-port divider arbiter.
// A fixed-latency divider model answers the DUT. A transaction-level model
// of the arbiter predicts every output on every cycle. Directed scenarios
// also pin key cycle numbers and results with literal values.
module tb_r5fp_idiv_arb;
    localparam int W   = 26;
    localparam int LAT = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] p0_N = '0, p0_D = '0, p1_N = '0, p1_D = '0;
    logic         p0_strobe = 1'b0, p1_strobe = 1'b0;
    logic         p0_ready, p1_ready, p0_done, p1_done;
    logic [W-1:0] p0_Quo, p0_Rem, p1_Quo, p1_Rem;
    logic [W-1:0] idiv_N, idiv_D;
    logic         idiv_strobe;
    logic [W-1:0] idiv_Quo = '0, idiv_Rem = '0;
    logic         idiv_done = 1'b0, idiv_ready = 1'b1;

    r5fp_idiv_arb #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .p0_N(p0_N), .p0_D(p0_D), .p0_strobe(p0_strobe), .p0_ready(p0_ready),
        .p0_Quo(p0_Quo), .p0_Rem(p0_Rem), .p0_done(p0_done),
        .p1_N(p1_N), .p1_D(p1_D), .p1_strobe(p1_strobe), .p1_ready(p1_ready),
        .p1_Quo(p1_Quo), .p1_Rem(p1_Rem), .p1_done(p1_done),
        .idiv_N(idiv_N), .idiv_D(idiv_D), .idiv_strobe(idiv_strobe),
        .idiv_Quo(idiv_Quo), .idiv_Rem(idiv_Rem), .idiv_done(idiv_done),
        .idiv_ready(idiv_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // ---------------- divider model (drives just after the rising edge) ----------------
    bit           div_busy = 0;
    int           div_due = 0;
    logic [W-1:0] div_n, div_d;
    bit           hold_ready = 0;
    bit           inject_spurious = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            idiv_done = 1'b0;
            if (div_busy && cyc == div_due) begin
                idiv_done = 1'b1;
                idiv_Quo  = (div_d == 0) ? '1 : div_n / div_d;
                idiv_Rem  = (div_d == 0) ? div_n : div_n % div_d;
                div_busy  = 0;
            end else if (!div_busy && inject_spurious) begin
                idiv_done = 1'b1;
                idiv_Quo  = 26'h2AAAAAA;
                idiv_Rem  = 26'h1555555;
                inject_spurious = 0;
            end
            if (idiv_strobe === 1'b1 && !div_busy) begin
                div_n    = idiv_N;
                div_d    = idiv_D;
                div_busy = 1;
                div_due  = cyc + LAT;
            end
            idiv_ready = !div_busy && !hold_ready;
        end
    end

    // ---------------- arbiter behavioural model (updates on the rising edge) ----------------
    bit           mv = 0;
    bit           m_pend[2];
    logic [W-1:0] m_n[2], m_d[2], m_q[2], m_r[2];
    bit           m_done[2];
    bit           m_last, m_busy, m_issued, m_gnt, m_strobe;

    always @(posedge clk) begin
        bit old_pend[2];
        bit in_strobe[2];
        logic [W-1:0] in_n[2], in_d[2];
        cyc++;
        old_pend = m_pend;
        in_strobe[0] = p0_strobe; in_strobe[1] = p1_strobe;
        in_n[0] = p0_N; in_n[1] = p1_N; in_d[0] = p0_D; in_d[1] = p1_D;
        if (reset) begin
            mv = 1;
            m_pend = '{0, 0};
            m_done = '{0, 0};
            m_q = '{'0, '0};
            m_r = '{'0, '0};
            m_last = 1; m_busy = 0; m_issued = 0; m_gnt = 0; m_strobe = 0;
        end else if (mv) begin
            m_done = '{0, 0};
            m_strobe = 0;
            if (!m_busy) begin
                // divider is free: hand it to a waiting request if it reports ready
                if (idiv_ready && (old_pend[0] || old_pend[1])) begin
                    m_gnt = (old_pend[0] && old_pend[1]) ? !m_last : old_pend[1];
                    m_busy = 1; m_issued = 0; m_strobe = 1;
                end
            end else if (!m_issued) begin
                m_issued = 1;   // the start pulse cycle; completions here do not count
            end else if (idiv_done) begin
                m_q[m_gnt] = idiv_Quo;
                m_r[m_gnt] = idiv_Rem;
                m_done[m_gnt] = 1;
                m_pend[m_gnt] = 0;
                m_last = m_gnt;
                m_busy = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (in_strobe[i] && !old_pend[i]) begin
                    m_pend[i] = 1; m_n[i] = in_n[i]; m_d[i] = in_d[i];
                end
            end
        end
    end

    // ---------------- compare and event log (falling edge) ----------------
    int strobe_cnt = 0, last_strobe_cyc = -1;
    int p0_done_cnt = 0, p1_done_cnt = 0, p0_done_cyc = -1, p1_done_cyc = -1;
    int done_seq[$];

    always @(negedge clk) begin
        if (mv) begin
            chk("p0_ready", p0_ready, !m_pend[0]);
            chk("p1_ready", p1_ready, !m_pend[1]);
            chk("p0_done", p0_done, m_done[0]);
            chk("p1_done", p1_done, m_done[1]);
            chk("p0_Quo", p0_Quo, m_q[0]);
            chk("p0_Rem", p0_Rem, m_r[0]);
            chk("p1_Quo", p1_Quo, m_q[1]);
            chk("p1_Rem", p1_Rem, m_r[1]);
            chk("idiv_strobe", idiv_strobe, m_strobe);
            chk("idiv_N", idiv_N, m_busy ? m_n[m_gnt] : '0);
            chk("idiv_D", idiv_D, m_busy ? m_d[m_gnt] : '0);
        end
        if (idiv_strobe === 1'b1) begin strobe_cnt++; last_strobe_cyc = cyc; end
        if (p0_done === 1'b1) begin p0_done_cnt++; p0_done_cyc = cyc; done_seq.push_back(0); end
        if (p1_done === 1'b1) begin p1_done_cnt++; p1_done_cyc = cyc; done_seq.push_back(1); end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int port, input int target, input int maxc);
        int k = 0;
        while (((port == 0) ? p0_done_cnt : p1_done_cnt) < target && k < maxc) begin
            step();
            k++;
        end
        chk($sformatf("timeout_p%0d", port), (((port == 0) ? p0_done_cnt : p1_done_cnt) >= target), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int t, c0, c1, rel;
        step(); step(); step();
        reset = 1'b0;
        step();
        // reset state pinned by literals
        chk("rst_p0_ready", p0_ready, 1);
        chk("rst_p1_ready", p1_ready, 1);
        chk("rst_p0_Quo", p0_Quo, 0);
        chk("rst_strobe", idiv_strobe, 0);

        // single request on port 0: 0xC00000 / 0x400000 = 3 r 0
        p0_N = 26'h0C00000; p0_D = 26'h0400000; p0_strobe = 1'b1; t = cyc;
        step();
        p0_strobe = 1'b0;
        wait_done(0, 1, 40);
        chk("single_strobe_cyc", last_strobe_cyc, t + 2);
        chk("single_done_cyc", p0_done_cyc, t + 16);
        chk("single_quo", p0_Quo, 3);
        chk("single_rem", p0_Rem, 0);
        chk("single_p1_quiet", p1_done_cnt, 0);

        // simultaneous requests after reset: port 0 first, then port 1, tie again to port 0
        do_reset();
        done_seq.delete();
        c0 = p0_done_cnt; c1 = p1_done_cnt;
        p0_N = 100; p0_D = 7; p1_N = 1000; p1_D = 33;
        p0_strobe = 1'b1; p1_strobe = 1'b1;
        step();
        p0_strobe = 1'b0; p1_strobe = 1'b0;
        wait_done(1, c1 + 1, 60);
        chk("tie1_order_len", done_seq.size(), 2);
        if (done_seq.size() >= 2) begin
            chk("tie1_first", done_seq[0], 0);
            chk("tie1_second", done_seq[1], 1);
        end
        chk("tie1_p1_issue", last_strobe_cyc, p0_done_cyc + 1);
        chk("tie1_p0_quo", p0_Quo, 14);
        chk("tie1_p0_rem", p0_Rem, 2);
        chk("tie1_p1_quo", p1_Quo, 30);
        chk("tie1_p1_rem", p1_Rem, 10);
        step();
        done_seq.delete();
        p0_N = 9; p0_D = 4; p1_N = 64; p1_D = 8;
        p0_strobe = 1'b1; p1_strobe = 1'b1;
        step();
        p0_strobe = 1'b0; p1_strobe = 1'b0;
        wait_done(1, c1 + 2, 60);
        if (done_seq.size() >= 1) chk("tie2_first", done_seq[0], 0);
        chk("tie2_p0_quo", p0_Quo, 2);
        chk("tie2_p1_quo", p1_Quo, 8);

        // back-to-back strobes on port 0: the second is dropped
        step();
        c0 = p0_done_cnt;
        p0_N = 50; p0_D = 5; p0_strobe = 1'b1;
        step();
        p0_N = 77; p0_D = 2;
        step();
        p0_strobe = 1'b0;
        wait_done(0, c0 + 1, 40);
        repeat (25) step();
        chk("b2b_done_cnt", p0_done_cnt, c0 + 1);
        chk("b2b_quo", p0_Quo, 10);
        chk("b2b_rem", p0_Rem, 0);

        // divider not ready for 20 cycles with port 1 pending
        hold_ready = 1;
        step(); step();
        c1 = p1_done_cnt; t = strobe_cnt;
        p1_N = 81; p1_D = 9; p1_strobe = 1'b1;
        step();
        p1_strobe = 1'b0;
        repeat (20) step();
        chk("hold_no_strobe", strobe_cnt, t);
        hold_ready = 0; rel = cyc;
        wait_done(1, c1 + 1, 40);
        chk("hold_issue_cyc", last_strobe_cyc, rel + 2);
        chk("hold_quo", p1_Quo, 9);

        // spurious completion while idle
        step();
        c0 = p0_done_cnt; c1 = p1_done_cnt;
        inject_spurious = 1;
        repeat (4) step();
        chk("spur_p0_done", p0_done_cnt, c0);
        chk("spur_p1_done", p1_done_cnt, c1);
        chk("spur_p0_quo", p0_Quo, 10);
        chk("spur_p1_quo", p1_Quo, 9);

        // reset in the middle of an operation, late completion discarded
        t = strobe_cnt;
        p0_N = 1000; p0_D = 10; p0_strobe = 1'b1;
        step();
        p0_strobe = 1'b0;
        repeat (6) step();
        chk("midrst_issued", strobe_cnt, t + 1);
        c0 = p0_done_cnt; c1 = p1_done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (16) step();
        chk("midrst_p0_ready", p0_ready, 1);
        chk("midrst_p1_ready", p1_ready, 1);
        chk("midrst_no_done", p0_done_cnt + p1_done_cnt, c0 + c1);
        chk("midrst_p0_quo", p0_Quo, 0);
        chk("midrst_p1_quo", p1_Quo, 0);

        // recovery: port 1 served normally afterwards
        p1_N = 45; p1_D = 6; p1_strobe = 1'b1;
        step();
        p1_strobe = 1'b0;
        wait_done(1, c1 + 1, 40);
        chk("recover_quo", p1_Quo, 7);
        chk("recover_rem", p1_Rem, 3);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
